stream_rr_arbiter: RTL and testbench

STREAM_RR_ARBITER -- requirements
Module: stream_rr_arbiter

---
 rtl/stream_rr_arbiter.sv | 120 ++++++++++++
 tb/tb_stream_rr_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_rr_arbiter.sv
// Packet-level round-robin arbiter merging NUM_IN valid-ready streams into one.
// A grant is held from arbitration until the granted stream's last beat transfers;
// every packet costs one idle arbitration cycle ahead of its first beat.
module stream_rr_arbiter #(
    parameter int NUM_IN = 4,
    parameter int DATA_W = 32,
    parameter int ID_W   = $clog2(NUM_IN)
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     en,
    input  logic                     sync_rst,
    input  logic [NUM_IN*DATA_W-1:0] in_data,
    input  logic [NUM_IN-1:0]        in_last,
    input  logic [NUM_IN-1:0]        in_valid,
    output logic [NUM_IN-1:0]        in_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ID_W-1:0]          out_src,
    output logic [15:0]              status_pkt_cnt
);

    typedef enum logic {IDLE, LOCKED} state_t;

    // Reset value of last_grant makes stream 0 the first to be searched.
    localparam logic [ID_W-1:0] LAST_INIT = ID_W'(NUM_IN - 1);

    state_t            state, state_nxt;
    logic [ID_W-1:0]   grant, grant_nxt;
    logic [ID_W-1:0]   last_grant, last_grant_nxt;
    logic [15:0]       pkt_cnt, pkt_cnt_nxt;
    logic [ID_W-1:0]   pick, cand;
    logic              pick_found;
    logic              active, xfer;
    logic [DATA_W-1:0] data_arr [NUM_IN];

    for (genvar i = 0; i < NUM_IN; i++) begin : g_unpack
        assign data_arr[i] = in_data[i*DATA_W +: DATA_W];
    end

    // Payload, last flag and source always reflect the current grant.
    assign out_data       = data_arr[grant];
    assign out_last       = in_last[grant];
    assign out_src        = grant;
    assign status_pkt_cnt = pkt_cnt;

    assign active    = en && (state == LOCKED);
    assign out_valid = active && in_valid[grant];
    assign xfer      = out_valid && out_ready;

    // Only the granted stream ever sees ready, and only while locked and enabled.
    always_comb begin
        in_ready = '0;
        if (active) in_ready[grant] = out_ready;
    end

    // Round-robin search from last_grant+1, wrapping at NUM_IN. Scanning from the
    // farthest candidate down lets the nearest valid stream win the last write.
    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
        cand       = '0;
        for (int k = NUM_IN; k >= 1; k--) begin
            cand = ID_W'((int'(last_grant) + k) % NUM_IN);
            if (in_valid[cand]) begin
                pick       = cand;
                pick_found = 1'b1;
            end
        end
    end

    // Next-state: arbitrate in IDLE, release the lock on a last-beat transfer.
    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant;
        last_grant_nxt = last_grant;
        pkt_cnt_nxt    = pkt_cnt;
        if (en) begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant_nxt = pick;
                        state_nxt = LOCKED;
                    end
                end
                LOCKED: begin
                    if (xfer && out_last) begin
                        last_grant_nxt = grant;
                        pkt_cnt_nxt    = pkt_cnt + 16'd1;
                        state_nxt      = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State registers; sync_rst abandons any packet in flight without counting it.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= LAST_INIT;
            pkt_cnt    <= '0;
        end else if (sync_rst) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= LAST_INIT;
            pkt_cnt    <= '0;
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            last_grant <= last_grant_nxt;
            pkt_cnt    <= pkt_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Directed bench for stream_rr_arbiter (NUM_IN=4, DATA_W=32). Inputs change on
// the falling edge; outputs are sampled 1ns later, well before the rising edge.
module tb_stream_rr_arbiter;

    logic         clk = 1'b0;
    logic         nrst;
    logic         en;
    logic         sync_rst;
    logic [127:0] in_data;
    logic [3:0]   in_last;
    logic [3:0]   in_valid;
    logic [3:0]   in_ready;
    logic [31:0]  out_data;
    logic         out_last;
    logic         out_valid;
    logic         out_ready;
    logic [1:0]   out_src;
    logic [15:0]  status_pkt_cnt;

    int checks = 0;
    int errors = 0;

    // Per-stream packet model: payload = base + beat index, last on final beat.
    logic [31:0] base [4];
    int          beat [4];
    int          plen [4];

    stream_rr_arbiter #(.NUM_IN(4), .DATA_W(32)) dut (
        .clk(clk), .nrst(nrst), .en(en), .sync_rst(sync_rst),
        .in_data(in_data), .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_last(out_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_src(out_src), .status_pkt_cnt(status_pkt_cnt)
    );

    always #5 clk = ~clk;

    task automatic apply(input logic [3:0] v, input logic rdy, input logic e, input logic sr);
        @(negedge clk);
        in_valid  = v;
        out_ready = rdy;
        en        = e;
        sync_rst  = sr;
        for (int i = 0; i < 4; i++) begin
            in_data[i*32 +: 32] = base[i] + 32'(beat[i]);
            in_last[i]          = (beat[i] == plen[i] - 1);
        end
        #1;
    endtask

    task automatic advance(input int s);
        beat[s] = (beat[s] + 1 == plen[s]) ? 0 : beat[s] + 1;
    endtask

    task automatic test_reset;
        nrst = 1'b0; en = 1'b0; sync_rst = 1'b0; out_ready = 1'b0;
        in_valid = '0; in_last = '0; in_data = '0;
        for (int i = 0; i < 4; i++) begin
            base[i] = 32'h100 * i; beat[i] = 0; plen[i] = 2;
        end
        #2;
        checks++;
        if ({out_valid, in_ready, out_src, status_pkt_cnt} !== 23'd0) begin
            errors++;
            $display("FAIL reset_hold got v=%b rdy=%b src=%0d cnt=%0d want all 0",
                     out_valid, in_ready, out_src, status_pkt_cnt);
        end
        @(negedge clk);
        nrst = 1'b1;
        for (int c = 0; c < 10; c++) begin
            apply(4'b0000, 1'b1, 1'b1, 1'b0);
            checks++;
            if ({out_valid, in_ready, out_src, status_pkt_cnt} !== 23'd0) begin
                errors++;
                $display("FAIL reset_idle cyc %0d got v=%b rdy=%b src=%0d cnt=%0d want all 0",
                         c, out_valid, in_ready, out_src, status_pkt_cnt);
            end
        end
    endtask

    // All four streams valid, 2-beat packets: grants 0,1,2,3,0, three cycles each.
    task automatic test_round_robin;
        int ph, src;
        for (int c = 0; c < 15; c++) begin
            apply(4'b1111, 1'b1, 1'b1, 1'b0);
            ph  = c % 3;
            src = (c / 3) % 4;
            if (c == 12) begin
                checks++;
                if (status_pkt_cnt !== 16'd4) begin
                    errors++;
                    $display("FAIL rr_count got %0d want 4", status_pkt_cnt);
                end
            end
            checks++;
            if (ph == 0) begin
                if ({out_valid, in_ready} !== 5'b0) begin
                    errors++;
                    $display("FAIL rr_bubble cyc %0d got v=%b rdy=%b want 0", c, out_valid, in_ready);
                end
            end else begin
                if ({out_valid, in_ready, out_src, out_last, out_data} !==
                    {1'b1, 4'(1 << src), 2'(src), (ph == 2), base[src] + 32'(ph - 1)}) begin
                    errors++;
                    $display("FAIL rr_beat cyc %0d got src=%0d rdy=%b last=%b data=%h want src=%0d",
                             c, out_src, in_ready, out_last, out_data, src);
                end
                advance(src);
            end
        end
    endtask

    // Stream 2 holds its grant for 3 beats while stream 0 waits.
    task automatic test_no_preempt;
        int exp_src [7] = '{-1, 2, 2, 2, -1, 0, 0};
        int s;
        plen[2] = 3;
        for (int c = 0; c < 7; c++) begin
            apply(4'b0101, 1'b1, 1'b1, 1'b0);
            s = exp_src[c];
            checks++;
            if (s < 0) begin
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL hold_bubble cyc %0d got v=%b want 0", c, out_valid);
                end
            end else begin
                if ({out_valid, out_src, out_data} !== {1'b1, 2'(s), base[s] + 32'(beat[s])}) begin
                    errors++;
                    $display("FAIL hold_beat cyc %0d got v=%b src=%0d data=%h want src=%0d",
                             out_valid, c, out_src, out_data, s);
                end
                advance(s);
            end
        end
        plen[2] = 2;
    endtask

    // out_ready toggles during a 4-beat packet; payload must step A0..A3 exactly once each.
    task automatic test_backpressure;
        logic rdy_pat [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        int k = 0;
        base[1] = 32'hA0; plen[1] = 4;
        apply(4'b0010, 1'b1, 1'b1, 1'b0);
        for (int c = 0; c < 7; c++) begin
            apply(4'b0010, rdy_pat[c], 1'b1, 1'b0);
            checks++;
            if ({out_valid, in_ready, out_src, out_data} !==
                {1'b1, (rdy_pat[c] ? 4'b0010 : 4'b0000), 2'd1, 32'hA0 + 32'(k)}) begin
                errors++;
                $display("FAIL bp_beat cyc %0d got v=%b rdy=%b data=%h want data=%h",
                         c, out_valid, in_ready, out_data, 32'hA0 + 32'(k));
            end
            if (rdy_pat[c]) begin
                k++;
                advance(1);
            end
        end
        apply(4'b0000, 1'b1, 1'b1, 1'b0);
        checks++;
        if ({out_valid, status_pkt_cnt} !== {1'b0, 16'd8}) begin
            errors++;
            $display("FAIL bp_end got v=%b cnt=%0d want v=0 cnt=8", out_valid, status_pkt_cnt);
        end
        base[1] = 32'h100; plen[1] = 2;
    endtask

    // en low for 5 cycles in mid-packet: everything stalls, grant stays on stream 3.
    task automatic test_enable_stall;
        plen[3] = 3;
        apply(4'b1001, 1'b1, 1'b1, 1'b0);
        apply(4'b1001, 1'b1, 1'b1, 1'b0);
        checks++;
        if ({out_valid, out_src, out_data} !== {1'b1, 2'd3, 32'h300}) begin
            errors++;
            $display("FAIL stall_first got v=%b src=%0d data=%h want src=3 data=300",
                     out_valid, out_src, out_data);
        end
        advance(3);
        for (int c = 0; c < 5; c++) begin
            apply(4'b1001, 1'b1, 1'b0, 1'b0);
            checks++;
            if ({out_valid, in_ready, out_src, status_pkt_cnt} !== {1'b0, 4'b0, 2'd3, 16'd8}) begin
                errors++;
                $display("FAIL stall_hold cyc %0d got v=%b rdy=%b src=%0d cnt=%0d want 0,0,3,8",
                         c, out_valid, in_ready, out_src, status_pkt_cnt);
            end
        end
        for (int c = 1; c < 3; c++) begin
            apply(4'b1001, 1'b1, 1'b1, 1'b0);
            checks++;
            if ({out_valid, in_ready, out_src, out_last, out_data} !==
                {1'b1, 4'b1000, 2'd3, (c == 2), 32'h300 + 32'(c)}) begin
                errors++;
                $display("FAIL stall_resume beat %0d got v=%b src=%0d last=%b data=%h",
                         c, out_valid, out_src, out_last, out_data);
            end
            advance(3);
        end
        apply(4'b0000, 1'b1, 1'b1, 1'b0);
        checks++;
        if ({out_valid, status_pkt_cnt} !== {1'b0, 16'd9}) begin
            errors++;
            $display("FAIL stall_end got v=%b cnt=%0d want v=0 cnt=9", out_valid, status_pkt_cnt);
        end
        plen[3] = 2;
    endtask

    // sync_rst after beat 1 of 3: packet dropped, counter cleared, stream 0 first again.
    task automatic test_sync_reset;
        plen[2] = 3;
        apply(4'b0100, 1'b1, 1'b1, 1'b0);
        apply(4'b0100, 1'b1, 1'b1, 1'b0);
        checks++;
        if ({out_valid, out_src, out_data} !== {1'b1, 2'd2, 32'h200}) begin
            errors++;
            $display("FAIL srst_first got v=%b src=%0d data=%h want src=2 data=200",
                     out_valid, out_src, out_data);
        end
        advance(2);
        apply(4'b0100, 1'b1, 1'b1, 1'b1);
        beat[2] = 0;
        apply(4'b0101, 1'b1, 1'b1, 1'b0);
        checks++;
        if ({out_valid, in_ready, out_src, status_pkt_cnt} !== {1'b0, 4'b0, 2'd0, 16'd0}) begin
            errors++;
            $display("FAIL srst_idle got v=%b rdy=%b src=%0d cnt=%0d want 0,0,0,0",
                     out_valid, in_ready, out_src, status_pkt_cnt);
        end
        apply(4'b0101, 1'b1, 1'b1, 1'b0);
        checks++;
        if ({out_valid, in_ready, out_src, out_data} !== {1'b1, 4'b0001, 2'd0, 32'h0}) begin
            errors++;
            $display("FAIL srst_regrant got v=%b rdy=%b src=%0d data=%h want src=0",
                     out_valid, in_ready, out_src, out_data);
        end
        plen[2] = 2;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_no_preempt();
        test_backpressure();
        test_enable_stall();
        test_sync_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
